multi_approach_light_ctrl: RTL and testbench
============================================

Name: multi_approach_light_ctrl

Overview:
Parametrised successor to the single-side traffic-light FSM. Controls one main approach, N_SIDE side approaches and one pedestrian walk phase. Has its own phase timer, latches sensor demand per approach, and serves side approaches in ascending index order. When nothing is demanded it rests in main green. Sits between the input synchronisers/programming logic and the lamp drivers.

Parameters:
N_SIDE, 2, number of side approaches (1..8)
CNT_W, 8, width of programmable durations, in ticks
T_BASE_DEF, 6, reset value of base green duration
T_EXT_DEF, 3, reset value of extension and walk duration
T_YEL_DEF, 2, reset value of yellow duration

Ports:
clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle timebase enable; all durations count tick pulses
sensor  in  N_SIDE  synchronised vehicle sensors, bit k = side k
walk_req  in  1  synchronised walk button, level or pulse
prog_load  in  1  single-cycle write strobe for durations
prog_sel  in  2  0=T_BASE, 1=T_EXT, 2=T_YEL, 3=ignored
prog_val  in  CNT_W  duration value; 0 is stored as 1
main_lights  out  3  {R,Y,G} for the main approach
side_lights  out  3*N_SIDE  {R,Y,G} per side; side k occupies bits [3k+2:3k]
walk  out  1  pedestrian walk lamp
walk_ack  out  1  one-cycle pulse on WALK entry
phase  out  3  current phase code
side_idx  out  IDX_W  side currently served; IDX_W = max(1, clog2(N_SIDE))

Behaviour:
- All outputs are registered.
- Reset values: main_lights=001, every side=100, walk=0, walk_ack=0, phase=MAIN_GRN, side_idx=0, dem=0, walk_pend=0, ext_used=0. Duration registers take their *_DEF values. Timer loads 2*T_BASE.
- Timer: CNT_W+1 bits. Loaded with duration-1 on phase entry, decremented on tick. Expiry = tick && count==0, so a duration D lasts exactly D ticks.
- dem[k]: set when sensor[k]=1. Cleared in the cycle SIDE_GRN[k] is entered; clear wins over a simultaneous set.
- walk_pend: set when walk_req=1. Cleared on WALK entry; a set in the same cycle wins over the clear.
- MAIN_GRN, duration T_BASE, or 2*T_BASE after reset or program. At expiry:
  - if walk_pend or any dem -> MAIN_YEL;
  - otherwise reload T_BASE and stay (rest).
- MAIN_YEL, T_YEL. At expiry:
  - walk_pend -> WALK;
  - else -> SIDE_GRN at the lowest pending k.
- WALK, T_EXT. All approaches red, walk=1, walk_ack pulses on entry. At expiry:
  - lowest pending k -> SIDE_GRN;
  - no demand -> MAIN_GRN (T_BASE).
- SIDE_GRN[k], T_BASE. At expiry:
  - if sensor[k] is live and ext_used=0, reload T_EXT and set ext_used=1;
  - otherwise -> SIDE_YEL[k].
  - ext_used clears on SIDE_GRN entry.
- SIDE_YEL[k], T_YEL. At expiry:
  - next pending index j>k -> SIDE_GRN[j];
  - otherwise -> MAIN_GRN (T_BASE).
  - Demand at indices <=k waits for the next round (fairness).
- Lights:
  - the served approach shows G or Y;
  - all other approaches show R;
  - main shows R in every phase except MAIN_GRN and MAIN_YEL.
- prog_load (sel 0..2):
  - writes the duration register;
  - forces MAIN_GRN with 2*T_BASE using the new value;
  - clears ext_used;
  - keeps dem and walk_pend.
  - prog_load beats an expiry in the same cycle.
  - sel=3 is a no-op, with no restart.
- Reset_n asserted at any point: all state returns to reset values immediately, without waiting for a clock edge.
- phase codes: 0 MAIN_GRN, 1 MAIN_YEL, 2 WALK, 3 SIDE_GRN, 4 SIDE_YEL.

Decomposition:
- Package tl_pkg holds:
  - phase enum;
  - lamp constants RED=100, YEL=010, GRN=001;
  - prog_sel codes;
  - function for "lowest set bit above index".
- Sub-module tl_phase_timer: load/decrement/expire counter with CNT_W+1 bits.

Test Plan:
Bench settings: N_SIDE=2, defaults, tick every cycle.
1. Reset, no inputs -> main_lights=001 for 12 cycles, then stays 001 (rest, reloads 6); sides 100; walk 0.
2. sensor=01 pulsed at cycle 3 -> main 001 until cycle 12, then 010 for 2, then side0 001 for 6, then 010 for 2, then main 001; side1 stays 100 throughout.
3. sensor=11 with bit1 held -> side0 green 6, side1 green 6+3 (extension), side1 yellow 2, main green; side1 is served again only after the next main green.
4. walk_req pulse plus sensor[0] -> after MAIN_YEL, walk_ack pulse, walk=1 for 3 with all lamps 100, then side0 green.
5. prog_load sel=2 val=4 during SIDE_GRN -> next cycle main=001, timer 12; next yellow lasts 4 ticks. Same test with val=0 -> yellow lasts 1 tick.
6. Reset_n low mid SIDE_YEL without a clock edge -> outputs show reset values immediately; after release, 12-tick main green.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and helpers for the multi-approach traffic-light controller.
package tl_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [1:0] {
    SEL_BASE = 2'd0,
    SEL_EXT  = 2'd1,
    SEL_YEL  = 2'd2,
    SEL_NONE = 2'd3
  } prog_sel_e;

  localparam int unsigned MAX_SIDE = 8;

  // Lowest set bit strictly above 'after'; -1 when none. Pass -1 to search all bits.
  function automatic int lowest_above(input logic [MAX_SIDE-1:0] mask, input int after);
    int r;
    r = -1;
    for (int unsigned i = 0; i < MAX_SIDE; i++)
      if (r < 0 && mask[i] && int'(i) > after) r = int'(i);
    return r;
  endfunction

endpackage

// File: rtl/multi_approach_light_ctrl_if.sv
// Sensor/programming inputs and lamp-driver outputs of the light controller.
interface multi_approach_light_ctrl_if #(
  parameter int unsigned N_SIDE = 2,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned IDX_W = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;

  logic                  tick;
  logic [N_SIDE-1:0]     sensor;
  logic                  walk_req;
  logic                  prog_load;
  logic [1:0]            prog_sel;
  logic [CNT_W-1:0]      prog_val;
  logic [2:0]            main_lights;
  logic [3*N_SIDE-1:0]   side_lights;
  logic                  walk;
  logic                  walk_ack;
  logic [2:0]            phase;
  logic [IDX_W-1:0]      side_idx;

  modport master (
    output tick, sensor, walk_req, prog_load, prog_sel, prog_val,
    input  main_lights, side_lights, walk, walk_ack, phase, side_idx
  );

  modport slave (
    input  tick, sensor, walk_req, prog_load, prog_sel, prog_val,
    output main_lights, side_lights, walk, walk_ack, phase, side_idx
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Phase duration counter: load duration-1, count down on tick, expire on tick at zero.
module tl_phase_timer #(
  parameter int unsigned     W       = 9,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= RST_VAL;
    else if (load)                  count <= load_val;
    else if (tick && count != '0)   count <= count - W'(1);
  end

  assign expired = tick && (count == '0);
endmodule

// File: rtl/multi_approach_light_ctrl.sv
// Traffic-light controller: one main approach, N_SIDE side approaches, one walk phase.
module multi_approach_light_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned N_SIDE     = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_BASE_DEF = 6,
  parameter int unsigned T_EXT_DEF  = 3,
  parameter int unsigned T_YEL_DEF  = 2
) (
  input logic                        clk,
  input logic                        Reset_n,
  multi_approach_light_ctrl_if.slave bus
);
  localparam int unsigned   TW      = CNT_W + 1;
  localparam int unsigned   IDX_W   = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;
  localparam logic [TW-1:0] TMR_RST = TW'(2 * T_BASE_DEF - 1);

  phase_e              phase_q, phase_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [N_SIDE-1:0]   dem_q, dem_n, dem_clr;
  logic                walk_pend_q, walk_pend_n;
  logic                ext_used_q, ext_used_n;
  logic [CNT_W-1:0]    t_base_q, t_base_n, t_ext_q, t_ext_n, t_yel_q, t_yel_n;
  logic [CNT_W-1:0]    prog_v;
  logic                tmr_load, tmr_expired;
  logic [TW-1:0]       tmr_val;
  logic                enter_side, enter_walk;
  logic [MAX_SIDE-1:0] sensor_pad;
  int                  first_j, next_j;

  logic [2:0]          main_n, main_q;
  logic [3*N_SIDE-1:0] side_n, side_q;
  logic                walk_n, walk_q, ack_n, ack_q;

  function automatic logic [TW-1:0] dur(input logic [CNT_W-1:0] d);
    return {1'b0, d} - TW'(1);
  endfunction

  function automatic logic [TW-1:0] dur2(input logic [CNT_W-1:0] d);
    return {d, 1'b0} - TW'(1);
  endfunction

  assign prog_v     = (bus.prog_val == '0) ? CNT_W'(1) : bus.prog_val;
  assign sensor_pad = MAX_SIDE'(bus.sensor);

  always_comb begin
    phase_n    = phase_q;
    idx_n      = idx_q;
    ext_used_n = ext_used_q;
    t_base_n   = t_base_q;
    t_ext_n    = t_ext_q;
    t_yel_n    = t_yel_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    enter_side = 1'b0;
    first_j    = lowest_above(MAX_SIDE'(dem_q), -1);
    next_j     = lowest_above(MAX_SIDE'(dem_q), int'(idx_q));

    // Programming restarts the cycle and takes priority over any expiry this cycle.
    if (bus.prog_load && prog_sel_e'(bus.prog_sel) != SEL_NONE) begin
      case (prog_sel_e'(bus.prog_sel))
        SEL_BASE: t_base_n = prog_v;
        SEL_EXT:  t_ext_n  = prog_v;
        default:  t_yel_n  = prog_v;
      endcase
      phase_n    = MAIN_GRN;
      ext_used_n = 1'b0;
      tmr_load   = 1'b1;
      tmr_val    = dur2(t_base_n);
    end else if (tmr_expired) begin
      tmr_load = 1'b1;
      tmr_val  = dur(t_base_q);
      unique case (phase_q)
        MAIN_GRN: begin
          if (walk_pend_q || |dem_q) begin
            phase_n = MAIN_YEL;
            tmr_val = dur(t_yel_q);
          end
        end
        MAIN_YEL, WALK: begin
          if (phase_q == MAIN_YEL && walk_pend_q) begin
            phase_n = WALK;
            tmr_val = dur(t_ext_q);
          end else if (first_j >= 0) begin
            phase_n    = SIDE_GRN;
            idx_n      = IDX_W'(first_j);
            enter_side = 1'b1;
          end else begin
            phase_n = MAIN_GRN;
          end
        end
        SIDE_GRN: begin
          if (sensor_pad[idx_q] && !ext_used_q) begin
            ext_used_n = 1'b1;
            tmr_val    = dur(t_ext_q);
          end else begin
            phase_n = SIDE_YEL;
            tmr_val = dur(t_yel_q);
          end
        end
        SIDE_YEL: begin
          if (next_j >= 0) begin
            phase_n    = SIDE_GRN;
            idx_n      = IDX_W'(next_j);
            enter_side = 1'b1;
          end else begin
            phase_n = MAIN_GRN;
          end
        end
        default: phase_n = MAIN_GRN;
      endcase
    end

    if (enter_side) ext_used_n = 1'b0;
  end

  assign enter_walk  = (phase_n == WALK) && (phase_q != WALK);
  assign dem_clr     = enter_side ? (N_SIDE'(1) << idx_n) : '0;
  assign dem_n       = (dem_q | bus.sensor) & ~dem_clr;
  assign walk_pend_n = bus.walk_req | (walk_pend_q & ~enter_walk);

  always_comb begin
    main_n = RED;
    side_n = '0;
    walk_n = (phase_n == WALK);
    ack_n  = enter_walk;
    if (phase_n == MAIN_GRN) main_n = GRN;
    if (phase_n == MAIN_YEL) main_n = YEL;
    for (int unsigned k = 0; k < N_SIDE; k++) begin
      side_n[3*k +: 3] = RED;
      if (idx_n == IDX_W'(k) && phase_n == SIDE_GRN) side_n[3*k +: 3] = GRN;
      if (idx_n == IDX_W'(k) && phase_n == SIDE_YEL) side_n[3*k +: 3] = YEL;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q     <= MAIN_GRN;
      idx_q       <= '0;
      dem_q       <= '0;
      walk_pend_q <= 1'b0;
      ext_used_q  <= 1'b0;
      t_base_q    <= CNT_W'(T_BASE_DEF);
      t_ext_q     <= CNT_W'(T_EXT_DEF);
      t_yel_q     <= CNT_W'(T_YEL_DEF);
      main_q      <= GRN;
      side_q      <= {N_SIDE{RED}};
      walk_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      phase_q     <= phase_n;
      idx_q       <= idx_n;
      dem_q       <= dem_n;
      walk_pend_q <= walk_pend_n;
      ext_used_q  <= ext_used_n;
      t_base_q    <= t_base_n;
      t_ext_q     <= t_ext_n;
      t_yel_q     <= t_yel_n;
      main_q      <= main_n;
      side_q      <= side_n;
      walk_q      <= walk_n;
      ack_q       <= ack_n;
    end
  end

  tl_phase_timer #(
    .W       (TW),
    .RST_VAL (TMR_RST)
  ) u_timer (
    .clk      (clk),
    .rst_n    (Reset_n),
    .tick     (bus.tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign bus.main_lights = main_q;
  assign bus.side_lights = side_q;
  assign bus.walk        = walk_q;
  assign bus.walk_ack    = ack_q;
  assign bus.phase       = phase_q;
  assign bus.side_idx    = idx_q;
endmodule

// File: tb/tb_multi_approach_light_ctrl.sv
// Scoreboard bench: per-cycle expected lamp/phase words queued per scenario, popped each sample.
module tb_multi_approach_light_ctrl;
  logic clk;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned edge_cnt;
  logic mon_en;
  string case_name;

  typedef struct {
    logic [13:0] word;
    logic        idx_chk;
    logic        idx;
  } exp_t;
  exp_t exp_q[$];

  multi_approach_light_ctrl_if #(.N_SIDE(2), .CNT_W(8)) bus ();

  multi_approach_light_ctrl #(
    .N_SIDE(2), .CNT_W(8), .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2)
  ) dut (
    .clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected output word {walk_ack, walk, phase, main, side1, side0}.
  function automatic logic [13:0] exp_word(input logic [2:0] ph, input logic idx, input logic ack);
    logic [2:0] m;
    logic [5:0] s;
    int k;
    k = idx ? 3 : 0;
    m = (ph == 3'd0) ? 3'b001 : (ph == 3'd1) ? 3'b010 : 3'b100;
    s = 6'b100_100;
    if (ph == 3'd3) s[k +: 3] = 3'b001;
    if (ph == 3'd4) s[k +: 3] = 3'b010;
    return {ack, (ph == 3'd2), ph, m, s};
  endfunction

  task automatic push_seg(input logic [2:0] ph, input logic idx, input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.word    = exp_word(ph, idx, (ph == 3'd2) && (i == 0));
      e.idx_chk = (ph == 3'd3) || (ph == 3'd4);
      e.idx     = idx;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s_s%0d", case_name, edge_cnt),
               32'({bus.walk_ack, bus.walk, bus.phase, bus.main_lights, bus.side_lights}),
               32'(e.word));
      if (e.idx_chk)
        check_eq($sformatf("%s_idx_s%0d", case_name, edge_cnt), 32'(bus.side_idx), 32'(e.idx));
    end
  end

  task automatic start_case(input string name);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    bus.sensor    = '0;
    bus.walk_req  = 1'b0;
    bus.prog_load = 1'b0;
    bus.prog_sel  = '0;
    bus.prog_val  = '0;
    case_name     = name;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_edge(input int unsigned e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) check_eq({case_name, "_drain"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic prog_case(input string name, input logic [7:0] val, input int unsigned yel);
    start_case(name);
    push_seg(0, 0, 12); push_seg(1, 0, 2); push_seg(3, 0, 2);
    push_seg(0, 0, 12); push_seg(1, 0, yel); push_seg(3, 0, 6);
    push_seg(4, 0, yel); push_seg(0, 0, 3);
    release_rst();
    wait_edge(2);  bus.sensor = 2'b01;
    wait_edge(3);  bus.sensor = 2'b00;
    wait_edge(15); bus.prog_load = 1'b1; bus.prog_sel = 2'd2; bus.prog_val = val;
    wait_edge(16); bus.prog_load = 1'b0; bus.sensor = 2'b01;
    wait_edge(17); bus.sensor = 2'b00;
    drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    mon_en   = 1'b0;
    bus.tick = 1'b1;

    start_case("rest");
    push_seg(0, 0, 30);
    release_rst();
    drain();

    start_case("side0");
    push_seg(0, 0, 12); push_seg(1, 0, 2); push_seg(3, 0, 6);
    push_seg(4, 0, 2); push_seg(0, 0, 8);
    release_rst();
    wait_edge(2); bus.sensor = 2'b01;
    wait_edge(3); bus.sensor = 2'b00;
    wait_edge(7); bus.prog_load = 1'b1; bus.prog_sel = 2'd3; bus.prog_val = 8'd9;
    wait_edge(8); bus.prog_load = 1'b0;
    drain();

    start_case("both_ext");
    push_seg(0, 0, 12); push_seg(1, 0, 2); push_seg(3, 0, 6); push_seg(4, 0, 2);
    push_seg(3, 1, 9);  push_seg(4, 1, 2); push_seg(0, 0, 6); push_seg(1, 0, 2);
    push_seg(3, 1, 3);
    release_rst();
    wait_edge(2); bus.sensor = 2'b11;
    wait_edge(3); bus.sensor = 2'b10;
    drain();

    start_case("walk");
    push_seg(0, 0, 12); push_seg(1, 0, 2); push_seg(2, 0, 3);
    push_seg(3, 0, 6);  push_seg(4, 0, 2); push_seg(0, 0, 4);
    release_rst();
    wait_edge(2); bus.sensor = 2'b01; bus.walk_req = 1'b1;
    wait_edge(3); bus.sensor = 2'b00; bus.walk_req = 1'b0;
    drain();

    prog_case("prog_yel4", 8'd4, 4);
    prog_case("prog_yel0", 8'd0, 1);

    start_case("async_rst");
    push_seg(0, 0, 12); push_seg(1, 0, 2); push_seg(3, 0, 6);
    release_rst();
    wait_edge(2); bus.sensor = 2'b01;
    wait_edge(3); bus.sensor = 2'b00;
    wait_edge(20);
    check_eq("pre_rst_phase", 32'(bus.phase), 32'(4));
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("rst_main",  32'(bus.main_lights), 32'(3'b001));
    check_eq("rst_side",  32'(bus.side_lights), 32'(6'b100100));
    check_eq("rst_walk",  32'({bus.walk, bus.walk_ack}), 32'(0));
    check_eq("rst_phase", 32'(bus.phase), 32'(0));
    check_eq("rst_idx",   32'(bus.side_idx), 32'(0));

    start_case("post_rst");
    push_seg(0, 0, 12); push_seg(1, 0, 2);
    release_rst();
    wait_edge(2); bus.sensor = 2'b01;
    wait_edge(3); bus.sensor = 2'b00;
    drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
